// File: rtl/ula_serial_ctrl_if.sv
// Request/response bundle between the MIPS control path and the bit-serial ULA sequencer.
// ULA_SERIAL_FLAGS_EN adds the registered zero/ovf flags alongside the result.
`timescale 1ns/1ps
interface ula_serial_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;
`ifdef ULA_SERIAL_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (output start, op, opa, opb, input busy, done, result, err, zero, ovf);
  modport slave  (input start, op, opa, opb, output busy, done, result, err, zero, ovf);
`else
  modport master (output start, op, opa, opb, input busy, done, result, err);
  modport slave  (input start, op, opa, opb, output busy, done, result, err);
`endif
endinterface

// File: rtl/ula_serial_ctrl.sv
// Bit-serial sequencer around a 1-bit ULA slice: LSB-first operands, carry looped back per bit.
// Optional ULA_SERIAL_FLAGS_EN adds registered zero/ovf outputs on the interface.
`timescale 1ns/1ps
module ula_serial_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  ula_serial_ctrl_if.slave   bus,
  output logic [2:0]         ULAcontrole,
  output logic               a,
  output logic               b,
  output logic               cin,
  output logic               addsub,
  input  logic               ULAsaida,
  input  logic               cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] acc_ext;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d, ctl_q, ctl_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             op_ok, is_arith, is_sub, is_slt, msb_ovf;
`ifdef ULA_SERIAL_FLAGS_EN
  logic             zero_q, zero_d, ovf_q, ovf_d;
`endif

  always_comb begin
    op_ok    = (bus.op == 3'b000) || (bus.op == 3'b001) || (bus.op == 3'b010) ||
               (bus.op == 3'b110) || (bus.op == 3'b111);
    // ADD/SUB/SLT all have op[1] set; SUB/SLT additionally have op[2] set
    is_arith = op_q[1];
    is_sub   = op_q[2];
    is_slt   = (op_q == 3'b111);
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ctl_d       = ctl_q;
    carry_d     = carry_q;
    err_d       = err_q;
    acc_ext     = {ULAsaida, acc_q};
    msb_ovf     = 1'b0;
    a           = 1'b0;
    b           = 1'b0;
    cin         = 1'b0;
    addsub      = 1'b0;
    ULAcontrole = ctl_q;
`ifdef ULA_SERIAL_FLAGS_EN
    zero_d      = zero_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (op_ok) begin
            a_d     = bus.opa;
            b_d     = bus.opb;
            op_d    = bus.op;
            ctl_d   = (bus.op == 3'b111) ? 3'b110 : bus.op;
            carry_d = bus.op[2];
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            result_d = '0;
            err_d    = 1'b1;
`ifdef ULA_SERIAL_FLAGS_EN
            zero_d   = 1'b1;
            ovf_d    = 1'b0;
`endif
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        a       = a_q[0];
        b       = b_q[0];
        addsub  = is_sub;
        cin     = is_arith & carry_q;
        acc_d   = acc_ext[WIDTH-1:1];
        carry_d = cout;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // carry into vs out of the MSB differ exactly on signed overflow
          msb_ovf  = cin ^ cout;
          result_d = is_slt ? {{(WIDTH-1){1'b0}}, ULAsaida ^ msb_ovf} : acc_ext;
          err_d    = 1'b0;
`ifdef ULA_SERIAL_FLAGS_EN
          zero_d   = (result_d == '0);
          ovf_d    = is_arith & ~is_slt & msb_ovf;
`endif
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      ctl_q    <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef ULA_SERIAL_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      ctl_q    <= ctl_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
`ifdef ULA_SERIAL_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.err    = err_q;
`ifdef ULA_SERIAL_FLAGS_EN
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_ula_serial_ctrl.sv
// Bench for ula_serial_ctrl: behavioural 1-bit slice, word-level reference model, directed + random ops.
// Flag checks are compiled in when ULA_SERIAL_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_ula_serial_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] ULAcontrole;
  logic a, b, cin, addsub, ULAsaida, cout;
  logic bb;

  int n_cmp = 0;
  int n_err = 0;

  ula_serial_ctrl_if #(.WIDTH(W)) bus_if ();

  ula_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .ULAcontrole(ULAcontrole), .a(a), .b(b), .cin(cin), .addsub(addsub),
    .ULAsaida(ULAsaida), .cout(cout)
  );

  always #5 clk = ~clk;

  // external 1-bit slice: AND, OR, or full adder with B inverted when subtracting
  always_comb begin
    bb = b ^ addsub;
    case (ULAcontrole)
      3'b000:  begin ULAsaida = a & b; cout = 1'b0; end
      3'b001:  begin ULAsaida = a | b; cout = 1'b0; end
      default: begin ULAsaida = a ^ bb ^ cin; cout = (a & bb) | (a & cin) | (bb & cin); end
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] r, output logic e, output logic v);
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0; e = 1'b0; v = 1'b0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin r = x + y; s = sx + sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b110: begin r = x - y; s = sx - sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b111: r = (sx < sy) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit mid_start);
    logic [W-1:0] er;
    logic ee, ev;
    int cyc, busy_cnt, lat;
    bit got;
    ref_model(o, x, y, er, ee, ev);
    lat = ee ? 1 : W + 1;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = o; bus_if.opa = x; bus_if.opb = y;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.opa = $urandom; bus_if.opb = $urandom;
    cyc = 1; busy_cnt = 0; got = 1'b0;
    while (!got && cyc <= W + 5) begin
      if (bus_if.busy) busy_cnt++;
      if (bus_if.done) got = 1'b1;
      else begin
        if (mid_start && cyc == 5) begin bus_if.start = 1'b1; bus_if.op = 3'b010; end
        if (mid_start && cyc == 6) bus_if.start = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    check_val("done_seen", 64'(got), 64'd1);
    check_val("latency", 64'(cyc), 64'(lat));
    check_val("busy_cycles", 64'(busy_cnt), 64'(lat));
    check_val("result", 64'(bus_if.result), 64'(er));
    check_val("err", 64'(bus_if.err), 64'(ee));
    if (!ee) check_val("ulactl", 64'(ULAcontrole), 64'((o == 3'b111) ? 3'b110 : o));
`ifdef ULA_SERIAL_FLAGS_EN
    check_val("zero", 64'(bus_if.zero), 64'(er == '0));
    check_val("ovf", 64'(bus_if.ovf), 64'(ev));
`endif
    $display("op=%b a=%08h b=%08h -> result=%08h err=%0b lat=%0d (model %08h)",
             o, x, y, bus_if.result, bus_if.err, cyc, er);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("done_after", 64'(bus_if.done), 64'd0);
      check_val("busy_after", 64'(bus_if.busy), 64'd0);
    end
    check_val("idle_slice", 64'({a, b, cin}), 64'd0);
  endtask

  logic [2:0] op_tbl [8];
  logic [W-1:0] corner [6];

  initial begin
    logic [W-1:0] x, y;
    op_tbl = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001};
    bus_if.start = 1'b0; bus_if.op = '0; bus_if.opa = '0; bus_if.opb = '0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 64'(bus_if.busy), 64'd0);
    check_val("rst_done", 64'(bus_if.done), 64'd0);
    check_val("rst_result", 64'(bus_if.result), 64'd0);
    check_val("rst_err", 64'(bus_if.err), 64'd0);
    check_val("rst_slice", 64'({ULAcontrole, a, b, cin, addsub}), 64'd0);
    rst = 1'b1;

    // abort an ADD mid-run
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = 3'b010; bus_if.opa = 32'h1234_5678; bus_if.opb = 32'h1111_1111;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("abort_busy", 64'(bus_if.busy), 64'd0);
    check_val("abort_result", 64'(bus_if.result), 64'd0);
    check_val("abort_done", 64'(bus_if.done), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check_val("abort_no_done", 64'(bus_if.done), 64'd0);
    end
    rst = 1'b1;
    do_op(3'b010, 32'd3, 32'd4, 1'b0);

    do_op(3'b010, 32'h5, 32'h3, 1'b0);
    do_op(3'b110, 32'h3, 32'h5, 1'b0);
    do_op(3'b010, 32'h7FFF_FFFF, 32'h1, 1'b0);
    do_op(3'b111, 32'h8000_0000, 32'h1, 1'b0);
    do_op(3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    do_op(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    do_op(3'b011, 32'h1, 32'h2, 1'b0);
    do_op(3'b010, 32'h10, 32'h20, 1'b0);

    for (int i = 0; i < 40; i++) begin
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
      do_op(op_tbl[$urandom_range(0, 7)], x, y, ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
